// File: rtl/cpu_defs.sv
// Shared CPU definitions: instruction field layout, the NOP/HALT encodings and the
// fetch-FSM state encoding.
package cpu_defs;

    localparam int unsigned OPC_W = 5;
    // The opcode sits in the top OPC_W bits of the instruction word.
    localparam int unsigned OPC_MSB_FROM_TOP = 0;

    localparam logic [OPC_W-1:0] HALT_OP = 5'b00001;
    localparam logic [15:0]      NOP     = 16'h0000;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PcHold   = 2'd0,
        PcInc    = 2'd1,
        PcBranch = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with hold / increment / redirect select.
module pc_unit
    import cpu_defs::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  pc_sel_e           pc_sel,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            PcHold:   pc_d = pc_q;
            PcInc:    pc_d = pc_q + 1'b1;  // wraps modulo 2^ADDR_W
            PcBranch: pc_d = branch_target;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else if (enable) begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID pipeline register, with stall, redirect and HALT handling.
module if_stage
    import cpu_defs::*;
#(
    parameter int unsigned    ADDR_W  = 8,
    parameter int unsigned    INSTR_W = 16,
    parameter logic [4:0]     HALT_OP = 5'b00001
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic               running
);

    fetch_state_e state_q, state_d;
    pc_sel_e      pc_sel;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic               is_halt;

    assign is_halt = (imem_rdata[INSTR_W-1 -: OPC_W] == HALT_OP);

    pc_unit #(
        .ADDR_W (ADDR_W)
    ) u_pc_unit (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .pc_sel        (pc_sel),
        .branch_target (branch_target),
        .pc            (pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_sel        = PcHold;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        unique case (state_q)
            StIdle: begin
                if_id_instr_d = '0;
                if_id_valid_d = 1'b0;
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (branch_taken) begin
                    pc_sel        = PcBranch;
                    if_id_instr_d = '0;
                    if_id_valid_d = 1'b0;
                end else if (!stall) begin
                    if_id_pc_d    = pc;
                    if_id_instr_d = imem_rdata;
                    if_id_valid_d = 1'b1;
                    if (is_halt) begin
                        state_d = StHalted;
                    end else begin
                        pc_sel = PcInc;
                    end
                end
            end
            StHalted: begin
                // A branch resolving behind the HALT means the HALT was speculative.
                if (branch_taken) begin
                    pc_sel        = PcBranch;
                    if_id_instr_d = '0;
                    if_id_valid_d = 1'b0;
                    state_d       = StRun;
                end else if (!stall) begin
                    if_id_instr_d = '0;
                    if_id_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            if_id_valid_q <= 1'b0;
        end else if (enable) begin
            state_q       <= state_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imem_addr   = pc;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign running     = (state_q == StRun);

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a combinational instruction memory model.
module tb_if_stage;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;

    logic               clock;
    logic               reset;
    logic               enable;
    logic               start;
    logic               stall;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [ADDR_W-1:0]  if_id_pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic               if_id_valid;
    logic               running;

    logic [INSTR_W-1:0] imem [256];

    int checks = 0;
    int errors = 0;

    if_stage #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .HALT_OP (5'b00001)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .running       (running)
    );

    assign imem_rdata = imem[imem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the whole observable state: address, IF/ID contents and running.
    task automatic chk_all(input string tag, input logic [7:0] addr, input logic [7:0] pc,
                           input logic [15:0] instr, input logic valid, input logic run);
        chk({tag, ".addr"}, 32'(imem_addr), 32'(addr));
        chk({tag, ".pc"}, 32'(if_id_pc), 32'(pc));
        chk({tag, ".instr"}, 32'(if_id_instr), 32'(instr));
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
        chk({tag, ".run"}, 32'(running), 32'(run));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h1000 | 16'(i);
        imem[0]    = 16'h1111;
        imem[1]    = 16'h2222;
        imem[2]    = 16'h3333;
        imem[3]    = 16'h4444;
        imem[4]    = 16'h5555;
        imem[5]    = 16'h0800;  // HALT
        imem[8'h40] = 16'hABCD;

        reset = 1'b0; enable = 1'b1; start = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        #3;
        chk_all("reset", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
        #4 reset = 1'b1;
        step();
        chk_all("idle", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk_all("start", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1);
        step();
        chk_all("fetch0", 8'h01, 8'h00, 16'h1111, 1'b1, 1'b1);
        step();
        chk_all("fetch1", 8'h02, 8'h01, 16'h2222, 1'b1, 1'b1);

        stall = 1'b1;
        step();
        chk_all("stall1", 8'h02, 8'h01, 16'h2222, 1'b1, 1'b1);
        step();
        chk_all("stall2", 8'h02, 8'h01, 16'h2222, 1'b1, 1'b1);
        stall = 1'b0;
        step();
        chk_all("fetch2", 8'h03, 8'h02, 16'h3333, 1'b1, 1'b1);

        // Branch beats a simultaneous stall.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
        step();
        stall = 1'b0; branch_taken = 1'b0;
        chk_all("flush40", 8'h40, 8'h02, 16'h0000, 1'b0, 1'b1);
        step();
        chk_all("fetch40", 8'h41, 8'h40, 16'hABCD, 1'b1, 1'b1);

        branch_taken = 1'b1; branch_target = 8'h04;
        step();
        branch_taken = 1'b0;
        chk_all("flush4", 8'h04, 8'h40, 16'h0000, 1'b0, 1'b1);
        step();
        chk_all("fetch4", 8'h05, 8'h04, 16'h5555, 1'b1, 1'b1);
        step();
        chk_all("halt", 8'h05, 8'h05, 16'h0800, 1'b1, 1'b0);
        start = 1'b1;  // ignored in HALTED
        for (int i = 0; i < 11; i++) begin
            step();
            chk_all("halted", 8'h05, 8'h05, 16'h0000, 1'b0, 1'b0);
        end
        start = 1'b0;

        branch_taken = 1'b1; branch_target = 8'h10;
        step();
        branch_taken = 1'b0;
        chk_all("resume", 8'h10, 8'h05, 16'h0000, 1'b0, 1'b1);
        step();
        chk_all("fetch10", 8'h11, 8'h10, 16'h1010, 1'b1, 1'b1);

        branch_taken = 1'b1; branch_target = 8'hFF;
        step();
        branch_taken = 1'b0;
        chk_all("flushff", 8'hFF, 8'h10, 16'h0000, 1'b0, 1'b1);
        step();
        chk_all("wrap", 8'h00, 8'hFF, 16'h10FF, 1'b1, 1'b1);
        step();
        chk_all("fetch0b", 8'h01, 8'h00, 16'h1111, 1'b1, 1'b1);

        // Disabled: a pending branch must not be taken.
        enable = 1'b0; branch_taken = 1'b1; branch_target = 8'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("frozen", 8'h01, 8'h00, 16'h1111, 1'b1, 1'b1);
        end
        enable = 1'b1; branch_taken = 1'b0;
        step();
        chk_all("unfrozen", 8'h02, 8'h01, 16'h2222, 1'b1, 1'b1);

        // Stall coinciding with a HALT fetch: the HALT is not latched.
        branch_taken = 1'b1; branch_target = 8'h05;
        step();
        branch_taken = 1'b0;
        chk_all("flush5", 8'h05, 8'h01, 16'h0000, 1'b0, 1'b1);
        stall = 1'b1;
        step();
        chk_all("stallhalt", 8'h05, 8'h01, 16'h0000, 1'b0, 1'b1);
        stall = 1'b0;
        step();
        chk_all("halt2", 8'h05, 8'h05, 16'h0800, 1'b1, 1'b0);
        stall = 1'b1;
        step();
        chk_all("haltstall", 8'h05, 8'h05, 16'h0800, 1'b1, 1'b0);
        stall = 1'b0;
        step();
        chk_all("haltbubble", 8'h05, 8'h05, 16'h0000, 1'b0, 1'b0);

        // Back to RUN, then asynchronous reset between edges.
        branch_taken = 1'b1; branch_target = 8'h01;
        step();
        branch_taken = 1'b0;
        step();
        chk_all("prereset", 8'h02, 8'h01, 16'h2222, 1'b1, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk_all("asyncreset", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
        #1 reset = 1'b1;
        step();
        step();
        chk_all("postreset", 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
